// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares one load-strobed, fixed-latency ALU between two requesters.
//   Round-robin arbitration, one operation in flight at a time. The winner's
//   operands are latched, the ALU is loaded for one cycle, the latency is
//   counted down, and the captured result is returned on a valid/ready
//   response channel to the requester that issued it.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready[1:0] request handshake, bit i = requester i
//   req{0,1}_a/_b/_op        operands and 6-bit opcode per requester
//   resp_valid/resp_ready    response handshake, resp_valid one-hot or zero
//   resp_data, resp_err      shared result / invalid-opcode flag
//   alu_load, alu_a, alu_b,
//   alu_opcode, alu_result   ALU-side interface
//   busy                     high whenever the FSM is not idle
module alu_issue_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 2,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [5:0]       req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [5:0]       req1_op,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             alu_load,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);
    localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] ALU_CNT = CW'(ALU_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [5:0]    OP_MUL  = 6'd5;
    localparam logic [5:0]    OP_MAX  = 6'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic             ptr;     // requester with priority in the next IDLE
    logic             gnt;     // requester owning the in-flight operation
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic [5:0]       op_q;
    logic             err_q;
    logic [CW-1:0]    cnt;

    logic             sel;
    logic [WIDTH-1:0] in_a, in_b;
    logic [5:0]       in_op;

    // Priority requester wins if valid; otherwise the other one is the
    // candidate (only granted when its own req_valid is high).
    always_comb begin
        sel   = req_valid[ptr] ? ptr : ~ptr;
        in_a  = sel ? req1_a  : req0_a;
        in_b  = sel ? req1_b  : req0_b;
        in_op = sel ? req1_op : req0_op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            gnt    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid[sel]) begin
                        gnt  <= sel;
                        a_q  <= in_a;
                        b_q  <= in_b;
                        op_q <= in_op;
                        if (in_op <= OP_MAX) begin
                            state <= ISSUE;
                        end else begin
                            // Bad opcode: answer immediately, ALU untouched.
                            data_q <= '0;
                            err_q  <= 1'b1;
                            state  <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= (op_q == OP_MUL) ? MUL_CNT : ALU_CNT;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CNT_ONE) begin
                        data_q <= alu_result;
                        err_q  <= 1'b0;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    if (resp_ready[gnt]) begin
                        ptr   <= ~gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state so they drop to zero the
    // instant reset asserts.
    logic drive_alu;
    assign drive_alu  = (state == ISSUE) || (state == WAIT);
    assign alu_load   = (state == ISSUE);
    assign alu_a      = drive_alu ? a_q  : '0;
    assign alu_b      = drive_alu ? b_q  : '0;
    assign alu_opcode = drive_alu ? op_q : '0;

    assign req_ready[0] = (state == IDLE) && req_valid[sel] && !sel;
    assign req_ready[1] = (state == IDLE) && req_valid[sel] &&  sel;

    assign resp_valid[0] = (state == RESP) && !gnt;
    assign resp_valid[1] = (state == RESP) &&  gnt;
    assign resp_data     = data_q;
    assign resp_err      = err_q;
    assign busy          = (state != IDLE);
endmodule
